// File: rtl/df_prof_pkg.sv
// Shared constants and helpers for the dataflow channel profiler.
package df_prof_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  // Channel-select width that stays legal for a single channel.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] lim;
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= lim) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/df_prof_chan.sv
// Per-channel statistics: occupancy, high-watermark, stall counters and sticky error.
module df_prof_chan
  import df_prof_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  parameter int OCC_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             wr_block,
  input  logic             rd_block,
  output logic [OCC_W-1:0] occ,
  output logic [OCC_W-1:0] max_occ,
  output logic [CNT_W-1:0] wstall,
  output logic [CNT_W-1:0] rstall,
  output logic             err
);

  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic [OCC_W-1:0] occ_next;
  logic             err_set;

  // Overflow and underflow leave occupancy pinned and only raise the error flag.
  always_comb begin
    occ_next = occ;
    err_set  = 1'b0;
    if (wr_en && !rd_en) begin
      if (occ == FULL) err_set = 1'b1;
      else             occ_next = occ + 1'b1;
    end else if (rd_en && !wr_en) begin
      if (occ == '0) err_set = 1'b1;
      else           occ_next = occ - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      occ     <= '0;
      max_occ <= '0;
      wstall  <= '0;
      rstall  <= '0;
      err     <= 1'b0;
    end else if (run) begin
      occ     <= occ_next;
      max_occ <= (occ_next > max_occ) ? occ_next : max_occ;
      err     <= err | err_set;
      if (wr_block) wstall <= CNT_W'(sat_inc(64'(wstall), CNT_W));
      if (rd_block) rstall <= CNT_W'(sat_inc(64'(rstall), CNT_W));
    end
  end

endmodule

// File: rtl/df_channel_profiler.sv
// Dataflow region profiler: run-control FSM, deadlock detector and registered
// per-channel readout over NUM_CH channel monitors.
module df_channel_profiler
  import df_prof_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int DEPTH     = 16,
  parameter  int CNT_W     = 32,
  parameter  int DL_CYCLES = 1024,
  localparam int OCC_W     = $clog2(DEPTH + 1),
  localparam int SEL_W     = sel_width(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              finish,
  input  logic [NUM_CH-1:0] wr_en,
  input  logic [NUM_CH-1:0] rd_en,
  input  logic [NUM_CH-1:0] wr_block,
  input  logic [NUM_CH-1:0] rd_block,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  sel,
  output logic              rd_valid,
  output logic [OCC_W-1:0]  rd_occ,
  output logic [OCC_W-1:0]  rd_max_occ,
  output logic [CNT_W-1:0]  rd_wstall,
  output logic [CNT_W-1:0]  rd_rstall,
  output logic [NUM_CH-1:0] err,
  output logic              deadlock,
  output logic [NUM_CH-1:0] deadlock_ch,
  output logic [1:0]        state
);

  localparam int DL_W = $clog2(DL_CYCLES);

  logic             run;
  logic [DL_W-1:0]  dl_cnt;
  logic             stuck;
  logic             dl_hit;
  logic [NUM_CH-1:0] blocked;

  logic [OCC_W-1:0] occ_v    [NUM_CH];
  logic [OCC_W-1:0] max_v    [NUM_CH];
  logic [CNT_W-1:0] wstall_v [NUM_CH];
  logic [CNT_W-1:0] rstall_v [NUM_CH];

  assign run     = (state == ST_RUN);
  assign blocked = wr_block | rd_block;
  assign stuck   = run && (|blocked) && !(|(wr_en | rd_en));
  assign dl_hit  = stuck && (dl_cnt == DL_W'(DL_CYCLES - 1));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    df_prof_chan #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .OCC_W (OCC_W)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .run      (run),
      .clear    (clear),
      .wr_en    (wr_en[i]),
      .rd_en    (rd_en[i]),
      .wr_block (wr_block[i]),
      .rd_block (rd_block[i]),
      .occ      (occ_v[i]),
      .max_occ  (max_v[i]),
      .wstall   (wstall_v[i]),
      .rstall   (rstall_v[i]),
      .err      (err[i])
    );
  end

  // Clear wins over enable/finish; a detected deadlock freezes the run like finish.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state       <= ST_IDLE;
      dl_cnt      <= '0;
      deadlock    <= 1'b0;
      deadlock_ch <= '0;
    end else begin
      dl_cnt <= stuck ? dl_cnt + 1'b1 : '0;
      case (state)
        ST_IDLE: if (enable) state <= ST_RUN;
        ST_RUN: begin
          if (dl_hit) begin
            deadlock    <= 1'b1;
            deadlock_ch <= blocked;
          end
          if (finish || dl_hit) state <= ST_FROZEN;
        end
        default: state <= state;
      endcase
    end
  end

  // Readout captures the selected channel's current counters one cycle after the request.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_occ     <= '0;
      rd_max_occ <= '0;
      rd_wstall  <= '0;
      rd_rstall  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (int'(sel) < NUM_CH) begin
          rd_occ     <= occ_v[sel];
          rd_max_occ <= max_v[sel];
          rd_wstall  <= wstall_v[sel];
          rd_rstall  <= rstall_v[sel];
        end else begin
          rd_occ     <= '0;
          rd_max_occ <= '0;
          rd_wstall  <= '0;
          rd_rstall  <= '0;
        end
      end
    end
  end

endmodule
